weight_bram_reader: RTL and testbench

- Sits directly downstream of the convolution control unit, on the weight path.
- Turns the control unit's address commands (`address_reset`, `bram_control_add1`, `bram_control_add2`, `bram_port_sel`) into dual-port weight-BRAM read addresses.
- Tracks BRAM read latency and returns `weight_from_bram_valid` plus the selected weight word, which the control unit uses to pace its preload/load FSM.

---
 rtl/accel_pkg.sv | 18 +
 rtl/bram_rd_valid_tracker.sv | 41 ++++
 rtl/weight_bram_reader.sv | 123 ++++++++++++
 tb/tb_weight_bram_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg
// Definitions shared by the convolution control unit and the weight-BRAM
// reader: the step encoding used for base-address updates, the default BRAM
// read latency, and the weight-BRAM address type.
package accel_pkg;

  localparam int ADDR_W               = 12;
  localparam int READ_LATENCY_DEFAULT = 2;

  typedef logic [ADDR_W-1:0] bram_addr_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_1    = 2'd1,
    STEP_2    = 2'd2
  } step_e;

endpackage

// File: rtl/bram_rd_valid_tracker.sv
// bram_rd_valid_tracker
// Counts the cycles since the BRAM address last changed. Valid goes high once
// the read data has had READ_LATENCY cycles to settle.
// Ports:
//   clk     in   single clock
//   rst     in   synchronous, active-high reset
//   restart in   address changed this cycle; start counting from 0
//   valid   out  BRAM data matches the current address
module bram_rd_valid_tracker #(
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic valid
);

  localparam logic [2:0] LAT_MAX = 3'(READ_LATENCY);

  logic [2:0] lat_cnt_q, lat_cnt_d;

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    if (restart) begin
      lat_cnt_d = '0;
    end else if (lat_cnt_q != LAT_MAX) begin
      lat_cnt_d = lat_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_q <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign valid = (lat_cnt_q == LAT_MAX);

endmodule

// File: rtl/weight_bram_reader.sv
// weight_bram_reader
// Turns control-unit step commands into dual-port weight-BRAM read addresses,
// tracks read latency and returns the selected weight word with a valid flag.
// Optional feature (macro WGT_ADDR_LIMIT_EN): sticky overflow flag when an
// accepted step lands past addr_limit.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   address_reset             base <= 0 (highest priority)
//   bram_control_add1/add2    step base by 1/2, honoured only while valid
//   bram_port_sel             0: port A data, 1: port B data
//   bram_addr_a/bram_addr_b   base / base+1 (wrapping)
//   bram_en                   read enable for both ports
//   bram_dout_a/bram_dout_b   BRAM read data
//   weight_data               muxed weight word
//   weight_from_bram_valid    weight_data belongs to current base
//   addr_limit/addr_overflow  only with WGT_ADDR_LIMIT_EN
module weight_bram_reader
  import accel_pkg::*;
#(
  parameter int BRAM_ADDRESS_WIDTH = ADDR_W,
  parameter int BRAM_DATA_WIDTH    = 32,
  parameter int READ_LATENCY       = READ_LATENCY_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          address_reset,
  input  logic                          bram_control_add1,
  input  logic                          bram_control_add2,
  input  logic                          bram_port_sel,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_a,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr_b,
  output logic                          bram_en,
  input  logic [BRAM_DATA_WIDTH-1:0]    bram_dout_a,
  input  logic [BRAM_DATA_WIDTH-1:0]    bram_dout_b,
`ifdef WGT_ADDR_LIMIT_EN
  input  logic [BRAM_ADDRESS_WIDTH-1:0] addr_limit,
  output logic                          addr_overflow,
`endif
  output logic [BRAM_DATA_WIDTH-1:0]    weight_data,
  output logic                          weight_from_bram_valid
);

  logic [BRAM_ADDRESS_WIDTH-1:0] base_q, base_d;
  step_e                         step;
  logic                          valid;
  logic                          restart;

  // Adds are consumer acknowledgements: only honoured once data is valid,
  // so a held add advances once per latency window. add2 beats add1.
  always_comb begin
    step = STEP_NONE;
    if (!address_reset && valid) begin
      if (bram_control_add2) begin
        step = STEP_2;
      end else if (bram_control_add1) begin
        step = STEP_1;
      end
    end
  end

  always_comb begin
    base_d = base_q + BRAM_ADDRESS_WIDTH'(step);
    if (address_reset) begin
      base_d = '0;
    end
  end

  // address_reset restarts the latency count even when base is already 0.
  assign restart = address_reset || (step != STEP_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end

  bram_rd_valid_tracker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_valid_tracker (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .valid  (valid)
  );

`ifdef WGT_ADDR_LIMIT_EN
  localparam int WIDE_W = BRAM_ADDRESS_WIDTH + 1;

  logic [WIDE_W-1:0] step_sum;
  logic              ovf_q, ovf_d;

  // Compare the pre-wrap sum so a step past the top of memory is caught.
  assign step_sum = {1'b0, base_q} + WIDE_W'(step);

  always_comb begin
    ovf_d = ovf_q;
    if (address_reset) begin
      ovf_d = 1'b0;
    end else if ((step != STEP_NONE) && (step_sum > {1'b0, addr_limit})) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign addr_overflow = ovf_q;
`endif

  assign bram_addr_a            = base_q;
  assign bram_addr_b            = base_q + 1'b1;
  assign bram_en                = !rst;
  assign weight_data            = bram_port_sel ? bram_dout_b : bram_dout_a;
  assign weight_from_bram_valid = valid;

endmodule

// File: tb/tb_weight_bram_reader.sv
module tb_weight_bram_reader;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int NV = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          address_reset = 1'b0;
  logic          add1 = 1'b0;
  logic          add2 = 1'b0;
  logic          port_sel = 1'b0;
  logic [AW-1:0] addr_a, addr_b;
  logic          en;
  logic [DW-1:0] dout_a = '0;
  logic [DW-1:0] dout_b = '0;
  logic [DW-1:0] wdata;
  logic          valid;
`ifdef WGT_ADDR_LIMIT_EN
  logic [AW-1:0] addr_limit = '1;
  logic          ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  weight_bram_reader #(
    .BRAM_ADDRESS_WIDTH(AW),
    .BRAM_DATA_WIDTH   (DW),
    .READ_LATENCY      (RL)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .address_reset         (address_reset),
    .bram_control_add1     (add1),
    .bram_control_add2     (add2),
    .bram_port_sel         (port_sel),
    .bram_addr_a           (addr_a),
    .bram_addr_b           (addr_b),
    .bram_en               (en),
    .bram_dout_a           (dout_a),
    .bram_dout_b           (dout_b),
`ifdef WGT_ADDR_LIMIT_EN
    .addr_limit            (addr_limit),
    .addr_overflow         (ovf),
`endif
    .weight_data           (wdata),
    .weight_from_bram_valid(valid)
  );

  typedef struct {
    logic          ar;
    logic          a1;
    logic          a2;
    logic          ps;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic [AW-1:0] ea;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at negedge+1; returns at negedge+1 with valid high or after a timeout.
  task automatic wait_valid(input string name);
    for (int k = 0; k < 8; k++) begin
      if (valid) break;
      @(negedge clk);
      #1;
    end
    if (!valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: valid timeout, got %0b expected 1", name, valid);
    end
  endtask

  task automatic do_step(input logic s1, input logic s2);
    wait_valid("step_wait");
    add1 = s1;
    add2 = s2;
    @(negedge clk);
    add1 = 1'b0;
    add2 = 1'b0;
    #1;
  endtask

  task automatic pulse_addr_reset();
    address_reset = 1'b1;
    @(negedge clk);
    address_reset = 1'b0;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ar    a1    a2    ps    dout_a        dout_b        addr  v     data
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h11110000, 32'h22220000, 12'd0, 1'b0, 32'h11110000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11110001, 32'h22220001, 12'd0, 1'b0, 32'h11110001};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h11110002, 32'h22220002, 12'd0, 1'b1, 32'h22220002};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11110003, 32'h22220003, 12'd1, 1'b0, 32'h11110003};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11110004, 32'h22220004, 12'd1, 1'b0, 32'h11110004};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11110005, 32'h22220005, 12'd1, 1'b1, 32'h11110005};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11110006, 32'h22220006, 12'd2, 1'b0, 32'h11110006};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11110007, 32'h22220007, 12'd2, 1'b0, 32'h11110007};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h11110008, 32'h22220008, 12'd2, 1'b1, 32'h22220008};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11110009, 32'h22220009, 12'd3, 1'b0, 32'h11110009};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1111000a, 32'h2222000a, 12'd3, 1'b0, 32'h1111000a};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1111000b, 32'h2222000b, 12'd3, 1'b1, 32'h1111000b};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1111000c, 32'h2222000c, 12'd3, 1'b1, 32'h1111000c};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1111000d, 32'h2222000d, 12'd4, 1'b0, 32'h1111000d};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1111000e, 32'h2222000e, 12'd4, 1'b0, 32'h1111000e};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h1111000f, 32'hdeadbeef, 12'd4, 1'b1, 32'hdeadbeef};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hcafef00d, 32'h22220010, 12'd6, 1'b0, 32'hcafef00d};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h11110011, 32'h22220011, 12'd6, 1'b0, 32'h22220011};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h11110012, 32'h22220012, 12'd6, 1'b1, 32'h11110012};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h11110013, 32'h22220013, 12'd8, 1'b0, 32'h11110013};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h11110014, 32'h22220014, 12'd8, 1'b0, 32'h11110014};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11110015, 32'h22220015, 12'd8, 1'b1, 32'h11110015};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h11110016, 32'h22220016, 12'd9, 1'b0, 32'h11110016};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h11110017, 32'h22220017, 12'd9, 1'b0, 32'h11110017};
    vecs[24] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h11110018, 32'h22220018, 12'd9, 1'b1, 32'h11110018};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h11110019, 32'h22220019, 12'd0, 1'b0, 32'h11110019};
    vecs[26] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h1111001a, 32'h2222001a, 12'd0, 1'b0, 32'h1111001a};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1111001b, 32'h2222001b, 12'd0, 1'b0, 32'h1111001b};
    vecs[28] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1111001c, 32'h2222001c, 12'd0, 1'b0, 32'h1111001c};
    vecs[29] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1111001d, 32'h2222001d, 12'd0, 1'b1, 32'h1111001d};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_addr_b", 32'(addr_b), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
`ifdef WGT_ADDR_LIMIT_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    // Table: one row per cycle, first row is the cycle before edge 0.
    rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      address_reset = vecs[i].ar;
      add1          = vecs[i].a1;
      add2          = vecs[i].a2;
      port_sel      = vecs[i].ps;
      dout_a        = vecs[i].da;
      dout_b        = vecs[i].db;
      #1;
      chk($sformatf("vec%0d_addr_a", i), 32'(addr_a), 32'(vecs[i].ea));
      chk($sformatf("vec%0d_addr_b", i), 32'(addr_b), 32'(vecs[i].ea + 12'd1));
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), wdata, vecs[i].ed);
      chk($sformatf("vec%0d_en", i), 32'(en), 32'd1);
      @(negedge clk);
    end
    address_reset = 1'b0;
    add1          = 1'b0;
    add2          = 1'b0;
    port_sel      = 1'b0;
    #1;

`ifdef WGT_ADDR_LIMIT_EN
    // Overflow: limit 8, base 7, add2 -> 9 with sticky flag
    addr_limit = 12'd8;
    pulse_addr_reset();
    chk("ovf_clear_start", 32'(ovf), 32'd0);
    do_step(1'b0, 1'b1);
    do_step(1'b0, 1'b1);
    do_step(1'b0, 1'b1);
    do_step(1'b1, 1'b0);
    chk("ovf_base7", 32'(addr_a), 32'd7);
    chk("ovf_at7", 32'(ovf), 32'd0);
    do_step(1'b0, 1'b1);
    chk("ovf_base9", 32'(addr_a), 32'd9);
    chk("ovf_set", 32'(ovf), 32'd1);
    do_step(1'b1, 1'b0);
    chk("ovf_base10", 32'(addr_a), 32'd10);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    pulse_addr_reset();
    chk("ovf_cleared", 32'(ovf), 32'd0);
    chk("ovf_clr_base", 32'(addr_a), 32'd0);
    addr_limit = '1;
`endif

    // Wrap with add2 from 4094
    pulse_addr_reset();
    for (int k = 0; k < 2047; k++) do_step(1'b0, 1'b1);
    chk("climb_addr_a", 32'(addr_a), 32'd4094);
    chk("climb_addr_b", 32'(addr_b), 32'd4095);
    do_step(1'b0, 1'b1);
    chk("wrap2_addr_a", 32'(addr_a), 32'd0);
    chk("wrap2_addr_b", 32'(addr_b), 32'd1);
    chk("wrap2_valid", 32'(valid), 32'd0);

    // Wrap with add1 from 4095
    for (int k = 0; k < 2047; k++) do_step(1'b0, 1'b1);
    do_step(1'b1, 1'b0);
    chk("top_addr_a", 32'(addr_a), 32'd4095);
    chk("top_addr_b", 32'(addr_b), 32'd0);
    do_step(1'b1, 1'b0);
    chk("wrap1_addr_a", 32'(addr_a), 32'd0);
    chk("wrap1_addr_b", 32'(addr_b), 32'd1);

    // rst mid-latency: base 1, one cycle into the latency window
    do_step(1'b1, 1'b0);
    chk("pre_rst_base", 32'(addr_a), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_addr_a", 32'(addr_a), 32'd0);
    chk("midrst_addr_b", 32'(addr_b), 32'd1);
    chk("midrst_en", 32'(en), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_valid0", 32'(valid), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_valid1", 32'(valid), 32'd1);
    chk("post_rst_addr", 32'(addr_a), 32'd0);

    // rst while valid is high at a nonzero base
    do_step(1'b0, 1'b1);
    wait_valid("pre_rst2");
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst2_valid", 32'(valid), 32'd0);
    chk("rst2_addr_a", 32'(addr_a), 32'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
